pc_flag_unit: RTL

//   Program-counter and branch-resolution stage directly downstream of the ALU.
//   - Captures the ALU compare flags (EQ, LT) into architectural flag registers.
//   - Resolves branches against the stored flags and advances the PC.
//   - Runs a start/halt/done handshake with the testbench or top level.
//   - Its PC output feeds instruction fetch. The ALU result path does not pass through this block.

---
 rtl/pc_flag_unit_pkg.sv | 25 ++
 rtl/pc_flag_unit_flag_reg.sv | 38 +++
 rtl/pc_flag_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/pc_flag_unit_pkg.sv
// Shared types for the PC / branch-resolution stage.
package pc_flag_unit_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_UNCOND = 2'd1,
        BR_LT     = 2'd2,
        BR_EQ     = 2'd3
    } br_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    // Branch decision from the stored (registered) flags only.
    function automatic logic branch_taken(input br_type_t br, input logic f_eq, input logic f_lt);
        return (br == BR_UNCOND) | ((br == BR_LT) & f_lt) | ((br == BR_EQ) & f_eq);
    endfunction

endpackage

// File: rtl/pc_flag_unit_flag_reg.sv
// Architectural compare-flag storage: write enable plus synchronous clear.
module pc_flag_unit_flag_reg (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic wr_en,
    input  logic eq_in,
    input  logic lt_in,
    output logic flag_eq,
    output logic flag_lt
);

    logic [1:0] flags_d;
    logic [1:0] flags_q;

    // Next flag value: clear on launch wins over a write.
    always_comb begin
        flags_d = flags_q;
        if (clr) begin
            flags_d = 2'b00;
        end else if (wr_en) begin
            flags_d = {eq_in, lt_in};
        end
    end

    // Flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 2'b00;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flag_eq = flags_q[1];
    assign flag_lt = flags_q[0];

endmodule

// File: rtl/pc_flag_unit.sv
// PC sequencer and branch resolver sitting right after the ALU.
// Start/Halt/Done handshake: Start is a level sampled only in IDLE or DONE;
// Halt is honoured only in RUN; Done is high for every cycle spent in DONE.
module pc_flag_unit
    import pc_flag_unit_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             FlagWr,
    input  logic             EQ,
    input  logic             LT,
    input  br_type_t         BrType,
    input  logic [PC_W-1:0]  BrTarget,
    input  logic             Halt,
    output logic [PC_W-1:0]  PC,
    output logic             FlagEQ,
    output logic             FlagLT,
    output logic             Taken,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt,
    output pc_state_t        state_dbg
);

    pc_state_t        state_d, state_q;
    logic [PC_W-1:0]  pc_d, pc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             done_d, done_q;
    logic             flag_clr;
    logic             flag_wr;
    logic             taken;

    pc_flag_unit_flag_reg u_flag_reg (
        .clk     (Clk),
        .rst     (Reset),
        .clr     (flag_clr),
        .wr_en   (flag_wr),
        .eq_in   (EQ),
        .lt_in   (LT),
        .flag_eq (FlagEQ),
        .flag_lt (FlagLT)
    );

    // Next-state, PC, counter and flag-control decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        flag_clr = 1'b0;
        flag_wr  = 1'b0;
        taken    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d  = RUN;
                    pc_d     = StartAddr;
                    cnt_d    = '0;
                    flag_clr = 1'b1;
                end
            end
            RUN: begin
                taken = branch_taken(BrType, FlagEQ, FlagLT);
                // The halt cycle still counts as a RUN cycle.
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (Halt) begin
                    state_d = DONE;
                end else begin
                    pc_d    = taken ? BrTarget : pc_q + PC_W'(1);
                    flag_wr = FlagWr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    // State, PC, counter and Done registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign PC        = pc_q;
    assign Taken     = taken;
    assign Done      = done_q;
    assign CycleCnt  = cnt_q;
    assign state_dbg = state_q;

endmodule
